// File: rtl/game_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// game_pkg: shared round-state encodings and BCD helpers
// Revision 1.0
// ------------------------------------------------------------------
package game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_RALLY = 3'd2,
        ST_POINT = 3'd3,
        ST_OVER  = 3'd4
    } game_state_t;

    localparam logic [15:0] BCD_MAX     = 16'h9999;
    localparam int          FRAME_CNT_W = 8;

    // Four-digit BCD increment: carry ripples digit by digit, pinned at 9999.
    function automatic logic [15:0] bcd_inc(input logic [15:0] value);
        logic [15:0] result;
        logic        carry;
        result = value;
        carry  = 1'b1;
        if (value != BCD_MAX) begin
            for (int d = 0; d < 4; d++) begin
                if (carry) begin
                    if (value[d*4 +: 4] >= 4'd9) begin
                        result[d*4 +: 4] = 4'd0;
                    end else begin
                        result[d*4 +: 4] = value[d*4 +: 4] + 4'd1;
                        carry            = 1'b0;
                    end
                end
            end
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_counter4.sv
`default_nettype none
// ------------------------------------------------------------------
// bcd_counter4: clearable, saturating 4-digit BCD up-counter
// Revision 1.0
// ------------------------------------------------------------------
module bcd_counter4
    import game_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        inc,
    output logic [15:0] value
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= 16'h0000;
        end else if (clear) begin
            value <= 16'h0000;
        end else if (inc) begin
            value <= bcd_inc(value);
        end
    end

endmodule
`default_nettype wire

// File: rtl/game_round_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------
// game_round_ctrl: serve timing, rally enable, lives and BCD score
// Revision 1.0
// ------------------------------------------------------------------
module game_round_ctrl
    import game_pkg::*;
#(
    parameter int LIVES        = 3,
    parameter int SERVE_FRAMES = 60,
    parameter int PAUSE_FRAMES = 90
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        frame_tick,
    input  logic        swing,
    input  logic        Break,
    output logic        serve,
    output logic        run,
    output logic [15:0] score,
    output logic [2:0]  lives,
    output logic        hit_beep,
    output logic        miss_beep,
    output logic        game_over
);

    localparam logic [2:0]             LIVES_INIT = 3'(LIVES);
    localparam logic [FRAME_CNT_W-1:0] SERVE_LAST = FRAME_CNT_W'(SERVE_FRAMES - 1);
    localparam logic [FRAME_CNT_W-1:0] PAUSE_LAST = FRAME_CNT_W'(PAUSE_FRAMES - 1);

    game_state_t             state;
    logic [FRAME_CNT_W-1:0]  frame_cnt;
    logic                    start_meta;
    logic                    start_sync;
    logic                    start_prev;
    logic                    start_edge;
    logic                    score_clear;
    logic                    score_inc;

    // Two flops of synchronisation plus a registered edge: start_edge lands
    // three clocks after the button rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_meta <= 1'b0;
            start_sync <= 1'b0;
            start_prev <= 1'b0;
            start_edge <= 1'b0;
        end else begin
            start_meta <= start;
            start_sync <= start_meta;
            start_prev <= start_sync;
            start_edge <= start_sync & ~start_prev;
        end
    end

    always_comb begin
        score_clear = 1'b0;
        score_inc   = 1'b0;
        if (start_edge && (state == ST_IDLE || state == ST_OVER)) begin
            score_clear = 1'b1;
        end
        // Break takes priority, so a coincident swing never scores.
        if (state == ST_RALLY && swing && !Break) begin
            score_inc = 1'b1;
        end
    end

    bcd_counter4 u_score (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (score_clear),
        .inc   (score_inc),
        .value (score)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            frame_cnt <= '0;
            lives     <= LIVES_INIT;
            serve     <= 1'b0;
            run       <= 1'b0;
            hit_beep  <= 1'b0;
            miss_beep <= 1'b0;
            game_over <= 1'b0;
        end else begin
            serve     <= 1'b0;
            hit_beep  <= 1'b0;
            miss_beep <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_edge) begin
                        state     <= ST_SERVE;
                        frame_cnt <= '0;
                        lives     <= LIVES_INIT;
                    end
                end
                ST_SERVE: begin
                    if (frame_tick) begin
                        if (frame_cnt == SERVE_LAST) begin
                            serve     <= 1'b1;
                            run       <= 1'b1;
                            state     <= ST_RALLY;
                            frame_cnt <= '0;
                        end else begin
                            frame_cnt <= frame_cnt + 1'b1;
                        end
                    end
                end
                ST_RALLY: begin
                    if (Break) begin
                        lives     <= lives - 3'd1;
                        miss_beep <= 1'b1;
                        run       <= 1'b0;
                        state     <= ST_POINT;
                        frame_cnt <= '0;
                    end else if (swing) begin
                        hit_beep <= 1'b1;
                    end
                end
                ST_POINT: begin
                    if (frame_tick) begin
                        if (frame_cnt == PAUSE_LAST) begin
                            frame_cnt <= '0;
                            if (lives == 3'd0) begin
                                state     <= ST_OVER;
                                game_over <= 1'b1;
                            end else begin
                                state <= ST_SERVE;
                            end
                        end else begin
                            frame_cnt <= frame_cnt + 1'b1;
                        end
                    end
                end
                ST_OVER: begin
                    if (start_edge) begin
                        state     <= ST_SERVE;
                        frame_cnt <= '0;
                        lives     <= LIVES_INIT;
                        game_over <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    frame_cnt <= '0;
                    run       <= 1'b0;
                    game_over <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_game_round_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_game_round_ctrl: randomized scoreboard bench for game_round_ctrl
// Revision 1.0
// ------------------------------------------------------------------
module tb_game_round_ctrl;

    localparam int LIVES        = 3;
    localparam int SERVE_FRAMES = 60;
    localparam int PAUSE_FRAMES = 90;

    localparam int P_IDLE  = 0;
    localparam int P_SERVE = 1;
    localparam int P_RALLY = 2;
    localparam int P_POINT = 3;
    localparam int P_OVER  = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        frame_tick;
    logic        swing;
    logic        Break;
    logic        serve;
    logic        run;
    logic [15:0] score;
    logic [2:0]  lives;
    logic        hit_beep;
    logic        miss_beep;
    logic        game_over;

    typedef struct {
        logic [2:0]  pulses;   // {serve, hit_beep, miss_beep}
        logic [15:0] score;
        logic [2:0]  lives;
    } ev_t;

    ev_t sb[$];
    int  m_phase, m_score, m_lives, m_cnt;
    int  tests = 0;
    int  fails = 0;
    int  hits  = 0;
    int  misses = 0;
    int  serves = 0;

    game_round_ctrl #(
        .LIVES        (LIVES),
        .SERVE_FRAMES (SERVE_FRAMES),
        .PAUSE_FRAMES (PAUSE_FRAMES)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .frame_tick (frame_tick),
        .swing      (swing),
        .Break      (Break),
        .serve      (serve),
        .run        (run),
        .score      (score),
        .lives      (lives),
        .hit_beep   (hit_beep),
        .miss_beep  (miss_beep),
        .game_over  (game_over)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        r[15:12] = 4'((v / 1000) % 10);
        r[11:8]  = 4'((v / 100) % 10);
        r[7:4]   = 4'((v / 10) % 10);
        r[3:0]   = 4'(v % 10);
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            if (fails <= 30) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push_ev(input logic [2:0] p);
        ev_t e;
        e.pulses = p;
        e.score  = to_bcd(m_score);
        e.lives  = 3'(m_lives);
        sb.push_back(e);
    endtask

    task automatic model_reset();
        m_phase = P_IDLE;
        m_score = 0;
        m_lives = LIVES;
        m_cnt   = 0;
        sb.delete();
    endtask

    // Game rules applied to the inputs the DUT sampled on this edge.
    task automatic model_step(input bit t, input bit sw, input bit br, input bit st_edge);
        case (m_phase)
            P_IDLE, P_OVER: begin
                if (st_edge) begin
                    m_phase = P_SERVE;
                    m_score = 0;
                    m_lives = LIVES;
                    m_cnt   = 0;
                end
            end
            P_SERVE: begin
                if (t) begin
                    m_cnt++;
                    if (m_cnt == SERVE_FRAMES) begin
                        push_ev(3'b100);
                        m_phase = P_RALLY;
                        m_cnt   = 0;
                    end
                end
            end
            P_RALLY: begin
                if (br) begin
                    m_lives--;
                    push_ev(3'b001);
                    m_phase = P_POINT;
                    m_cnt   = 0;
                end else if (sw) begin
                    if (m_score < 9999) m_score++;
                    push_ev(3'b010);
                end
            end
            default: begin
                if (t) begin
                    m_cnt++;
                    if (m_cnt == PAUSE_FRAMES) begin
                        m_phase = (m_lives == 0) ? P_OVER : P_SERVE;
                        m_cnt   = 0;
                    end
                end
            end
        endcase
    endtask

    task automatic drive(input bit t, input bit sw, input bit br, input bit st_edge);
        frame_tick = t;
        swing      = sw;
        Break      = br;
        @(posedge clk);
        model_step(t, sw, br, st_edge);
        #1;
        frame_tick = 1'b0;
        swing      = 1'b0;
        Break      = 1'b0;
    endtask

    // The button edge reaches the state machine on the fourth edge after it rises.
    task automatic press_start();
        start = 1'b1;
        repeat (3) drive(0, 0, 0, 0);
        drive(0, 0, 0, 1);
        start = 1'b0;
        repeat (2) drive(0, 0, 0, 0);
    endtask

    // One frame tick with random swing/Break noise and a random gap.
    task automatic tick_noisy();
        drive(1, ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0), 0);
        repeat ($urandom_range(0, 2)) drive(0, 0, 0, 0);
    endtask

    task automatic ticks_until(input int phase);
        int guard;
        guard = 0;
        while (m_phase != phase && guard < 2000) begin
            tick_noisy();
            guard++;
        end
        check("phase_reached", 32'(m_phase == phase), 32'd1);
    endtask

    // Monitor: pops an expected event whenever the DUT emits a pulse, and
    // tracks the level outputs against the model every cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            check("no_pulse_in_reset", {29'd0, serve, hit_beep, miss_beep}, 32'd0);
        end else begin
            if (serve || hit_beep || miss_beep) begin
                if (hit_beep)  hits++;
                if (miss_beep) misses++;
                if (serve)     serves++;
                if (sb.size() == 0) begin
                    check("unexpected_pulse", {29'd0, serve, hit_beep, miss_beep}, 32'd0);
                end else begin
                    ev_t e;
                    e = sb.pop_front();
                    check("pulse_kind", {29'd0, serve, hit_beep, miss_beep}, {29'd0, e.pulses});
                    check("pulse_score", {16'd0, score}, {16'd0, e.score});
                    check("pulse_lives", {29'd0, lives}, {29'd0, e.lives});
                end
            end
            check("run_level", {31'd0, run}, 32'(m_phase == P_RALLY));
            check("game_over_level", {31'd0, game_over}, 32'(m_phase == P_OVER));
            check("score_track", {16'd0, score}, {16'd0, to_bcd(m_score)});
            check("lives_track", {29'd0, lives}, 32'(m_lives));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] held;
        int guard;
        rst_n = 1'b0;
        start = 1'b0;
        frame_tick = 1'b0;
        swing = 1'b0;
        Break = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state and idle frames
        check("reset_score", {16'd0, score}, 32'h0);
        check("reset_lives", {29'd0, lives}, 32'd3);
        check("reset_run", {31'd0, run}, 32'd0);
        check("reset_game_over", {31'd0, game_over}, 32'd0);
        repeat (100) tick_noisy();
        check("idle_no_serve", 32'(serves), 32'd0);

        // Start, serve after 60 frames
        press_start();
        ticks_until(P_RALLY);
        drive(0, 0, 0, 0);
        check("one_serve", 32'(serves), 32'd1);
        check("run_after_serve", {31'd0, run}, 32'd1);

        // Start ignored mid-rally, then 12 swings
        press_start();
        hits = 0;
        for (int i = 0; i < 12; i++) begin
            drive($urandom_range(0, 1), 1, 0, 0);
            repeat ($urandom_range(0, 1)) drive($urandom_range(0, 1), 0, 0, 0);
        end
        drive(0, 0, 0, 0);
        check("score_12", {16'd0, score}, 32'h0012);
        check("hit_count_12", 32'(hits), 32'd12);

        // Climb to 9998 then saturate
        for (int i = 0; i < 9986; i++) drive(0, 1, 0, 0);
        check("score_9998", {16'd0, score}, 32'h9998);
        repeat (3) drive(0, 1, 0, 0);
        check("score_sat", {16'd0, score}, 32'h9999);

        // Swing and Break together: Break wins
        misses = 0;
        drive(1, 1, 1, 0);
        drive(0, 0, 0, 0);
        check("both_score", {16'd0, score}, 32'h9999);
        check("both_lives", {29'd0, lives}, 32'd2);
        check("both_run", {31'd0, run}, 32'd0);
        check("both_miss_count", 32'(misses), 32'd1);
        ticks_until(P_SERVE);
        ticks_until(P_RALLY);

        // Random rallies until the game ends
        guard = 0;
        while (m_phase != P_OVER && guard < 20000) begin
            if (m_phase == P_RALLY) begin
                case ($urandom_range(0, 9))
                    0:       drive($urandom_range(0, 1), $urandom_range(0, 1), 1, 0);
                    1, 2:    drive($urandom_range(0, 1), 0, 0, 0);
                    default: drive($urandom_range(0, 1), 1, 0, 0);
                endcase
            end else begin
                tick_noisy();
            end
            guard++;
        end
        drive(0, 0, 0, 0);
        check("game_over_set", {31'd0, game_over}, 32'd1);
        check("over_lives", {29'd0, lives}, 32'd0);
        held = score;
        repeat (5) drive(1, 1, 1, 0);
        check("over_score_held", {16'd0, score}, {16'd0, held});
        press_start();
        check("restart_score", {16'd0, score}, 32'h0);
        check("restart_lives", {29'd0, lives}, 32'd3);
        check("restart_game_over", {31'd0, game_over}, 32'd0);

        // Async reset mid-rally with a swing pending
        ticks_until(P_RALLY);
        drive(0, 1, 0, 0);
        swing = 1'b1;
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check("async_score", {16'd0, score}, 32'h0);
        check("async_lives", {29'd0, lives}, 32'd3);
        check("async_run", {31'd0, run}, 32'd0);
        check("async_pulses", {29'd0, serve, hit_beep, miss_beep}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        swing = 1'b0;
        repeat (4) drive(0, 0, 0, 0);

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
